// File: rtl/tiny32_mem_arbiter.sv
// tiny32_mem_arbiter
//   Shares one tiny32 memory port between master 0 (CPU) and master 1
//   (DMA/debug). Each access runs IDLE -> STROBE -> DONE -> IDLE: the
//   winner's strobes, address and write data are latched at grant, held on
//   the memory port for at least WAIT_STATES cycles (longer while mem_ready
//   is low), then the owner sees a one-cycle ready pulse in DONE.
//
// Parameters
//   ADDR_WIDTH   address width of all ports
//   WAIT_STATES  minimum strobe cycles (>= 1)
//   PRIO_MODE    0 = round-robin, 1 = fixed priority (master 0 wins ties)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   mX_nrd / mX_nwr            master read / byte-lane write strobes (active low)
//   mX_address / mX_wdata      master address / write data
//   mX_rdata                   registered read data for master X
//   mX_ready                   combinational ready; low = stall
//   mem_nrd / mem_nwr          registered memory strobes (active low)
//   mem_address / mem_wdata    registered memory address / write data
//   mem_rdata / mem_ready      memory read data / memory ready
//   grant                      00 idle, 01 master 0, 10 master 1
module tiny32_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned PRIO_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_nrd,
  input  logic [3:0]            m0_nwr,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [31:0]           m0_wdata,
  output logic [31:0]           m0_rdata,
  output logic                  m0_ready,
  input  logic                  m1_nrd,
  input  logic [3:0]            m1_nwr,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [31:0]           m1_wdata,
  output logic [31:0]           m1_rdata,
  output logic                  m1_ready,
  output logic                  mem_nrd,
  output logic [3:0]            mem_nwr,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {IDLE, STROBE, DONE} state_t;

  localparam logic [31:0] CNT_INIT = WAIT_STATES - 1;

  state_t      state;
  logic        owner;
  logic        last_owner;
  logic [31:0] cnt;
  logic        req0;
  logic        req1;
  logic        win;

  assign req0 = !m0_nrd | (m0_nwr != 4'hF);
  assign req1 = !m1_nrd | (m1_nwr != 4'hF);

  assign m0_ready = !req0 | (state == DONE && owner == 1'b0);
  assign m1_ready = !req1 | (state == DONE && owner == 1'b1);

  // Tie-break: round-robin favours the master that did not own the port last.
  always_comb begin
    win = 1'b0;
    if (req0 && req1)
      win = (PRIO_MODE != 0) ? 1'b0 : ~last_owner;
    else if (req1)
      win = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      cnt         <= '0;
      grant       <= '0;
      mem_nrd     <= 1'b1;
      mem_nwr     <= '1;
      mem_address <= '0;
      mem_wdata   <= '0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner       <= win;
            last_owner  <= win;
            grant       <= win ? 2'b10 : 2'b01;
            mem_nrd     <= win ? m1_nrd : m0_nrd;
            mem_nwr     <= win ? m1_nwr : m0_nwr;
            mem_address <= win ? m1_address : m0_address;
            mem_wdata   <= win ? m1_wdata : m0_wdata;
            cnt         <= CNT_INIT;
            state       <= STROBE;
          end
        end
        STROBE: begin
          if (cnt != 0) begin
            cnt <= cnt - 1;
          end else if (mem_ready) begin
            state   <= DONE;
            mem_nrd <= 1'b1;
            mem_nwr <= '1;
            // mem_nrd still holds the latched read strobe on this edge.
            if (!mem_nrd) begin
              if (owner)
                m1_rdata <= mem_rdata;
              else
                m0_rdata <= mem_rdata;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          grant <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny32_mem_arbiter.sv
module tb_tiny32_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_nrd, m1_nrd;
  logic [3:0]  m0_nwr, m1_nwr;
  logic [31:0] m0_address, m1_address, m0_wdata, m1_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  // round-robin, WS=1
  logic [31:0] r_m0_rdata, r_m1_rdata, r_mem_address, r_mem_wdata;
  logic        r_m0_ready, r_m1_ready, r_mem_nrd;
  logic [3:0]  r_mem_nwr;
  logic [1:0]  r_grant;
  // fixed priority, WS=1
  logic [31:0] p_m0_rdata, p_m1_rdata, p_mem_address, p_mem_wdata;
  logic        p_m0_ready, p_m1_ready, p_mem_nrd;
  logic [3:0]  p_mem_nwr;
  logic [1:0]  p_grant;
  // round-robin, WS=3
  logic [31:0] w_m0_rdata, w_m1_rdata, w_mem_address, w_mem_wdata;
  logic        w_m0_ready, w_m1_ready, w_mem_nrd;
  logic [3:0]  w_mem_nwr;
  logic [1:0]  w_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tiny32_mem_arbiter #(.ADDR_WIDTH(32), .WAIT_STATES(1), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_nrd(m0_nrd), .m0_nwr(m0_nwr), .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_rdata(r_m0_rdata), .m0_ready(r_m0_ready),
    .m1_nrd(m1_nrd), .m1_nwr(m1_nwr), .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_rdata(r_m1_rdata), .m1_ready(r_m1_ready),
    .mem_nrd(r_mem_nrd), .mem_nwr(r_mem_nwr), .mem_address(r_mem_address),
    .mem_wdata(r_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(r_grant));

  tiny32_mem_arbiter #(.ADDR_WIDTH(32), .WAIT_STATES(1), .PRIO_MODE(1)) dut_prio (
    .clk(clk), .reset(reset),
    .m0_nrd(m0_nrd), .m0_nwr(m0_nwr), .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_rdata(p_m0_rdata), .m0_ready(p_m0_ready),
    .m1_nrd(m1_nrd), .m1_nwr(m1_nwr), .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_rdata(p_m1_rdata), .m1_ready(p_m1_ready),
    .mem_nrd(p_mem_nrd), .mem_nwr(p_mem_nwr), .mem_address(p_mem_address),
    .mem_wdata(p_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(p_grant));

  tiny32_mem_arbiter #(.ADDR_WIDTH(32), .WAIT_STATES(3), .PRIO_MODE(0)) dut_ws3 (
    .clk(clk), .reset(reset),
    .m0_nrd(m0_nrd), .m0_nwr(m0_nwr), .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_rdata(w_m0_rdata), .m0_ready(w_m0_ready),
    .m1_nrd(m1_nrd), .m1_nwr(m1_nwr), .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_rdata(w_m1_rdata), .m1_ready(w_m1_ready),
    .mem_nrd(w_mem_nrd), .mem_nwr(w_mem_nwr), .mem_address(w_mem_address),
    .mem_wdata(w_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(w_grant));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m0_nrd = 1'b1; m0_nwr = 4'hF; m0_address = '0; m0_wdata = '0;
    m1_nrd = 1'b1; m1_nwr = 4'hF; m1_address = '0; m1_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (r_mem_nrd !== 1'b1) begin errors++; $display("FAIL rst_mem_nrd got %b exp 1", r_mem_nrd); end
    checks++; if (r_mem_nwr !== 4'hF) begin errors++; $display("FAIL rst_mem_nwr got %h exp f", r_mem_nwr); end
    checks++; if (r_mem_address !== 32'h0) begin errors++; $display("FAIL rst_mem_address got %h exp 0", r_mem_address); end
    checks++; if (r_mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", r_mem_wdata); end
    checks++; if (r_grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", r_grant); end
    checks++; if (r_m0_rdata !== 32'h0 || r_m1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", r_m0_rdata, r_m1_rdata); end
    checks++; if (r_m0_ready !== 1'b1 || r_m1_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b%b exp 11", r_m0_ready, r_m1_ready); end
    checks++; if (p_grant !== 2'b00 || w_mem_nrd !== 1'b1) begin errors++; $display("FAIL rst_other got %b/%b exp 00/1", p_grant, w_mem_nrd); end
  endtask

  task automatic test_single_read();
    m0_nrd = 1'b0; m0_address = 32'h4000_0010; mem_rdata = 32'hDEAD_BEEF; mem_ready = 1'b1;
    #1;
    checks++; if (r_m0_ready !== 1'b0 || r_mem_nrd !== 1'b1) begin errors++; $display("FAIL sr_c0 got ready %b nrd %b exp 0 1", r_m0_ready, r_mem_nrd); end
    step();
    checks++; if (r_mem_nrd !== 1'b0 || r_mem_nwr !== 4'hF) begin errors++; $display("FAIL sr_c1_strobe got %b %h exp 0 f", r_mem_nrd, r_mem_nwr); end
    checks++; if (r_mem_address !== 32'h4000_0010) begin errors++; $display("FAIL sr_c1_addr got %h exp 40000010", r_mem_address); end
    checks++; if (r_grant !== 2'b01 || r_m0_ready !== 1'b0) begin errors++; $display("FAIL sr_c1_grant got %b rdy %b exp 01 0", r_grant, r_m0_ready); end
    step();
    checks++; if (r_mem_nrd !== 1'b1 || r_m0_ready !== 1'b1 || r_grant !== 2'b01) begin errors++; $display("FAIL sr_c2 got nrd %b rdy %b grant %b exp 1 1 01", r_mem_nrd, r_m0_ready, r_grant); end
    checks++; if (r_m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sr_rdata got %h exp deadbeef", r_m0_rdata); end
    m0_nrd = 1'b1;
    step();
    checks++; if (r_grant !== 2'b00 || r_mem_nrd !== 1'b1 || r_m0_ready !== 1'b1) begin errors++; $display("FAIL sr_c3 got grant %b nrd %b rdy %b exp 00 1 1", r_grant, r_mem_nrd, r_m0_ready); end
  endtask

  task automatic test_round_robin();
    logic [1:0] eg  [12] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    logic       en  [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       er0 [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       er1 [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    m0_nrd = 1'b0; m0_address = 32'h0000_0100;
    m1_nrd = 1'b0; m1_address = 32'h0000_0200;
    mem_rdata = 32'hA000_0000; mem_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++; if (r_grant !== eg[i-1]) begin errors++; $display("FAIL rr_grant c%0d got %b exp %b", i, r_grant, eg[i-1]); end
      checks++; if (r_mem_nrd !== en[i-1]) begin errors++; $display("FAIL rr_mem_nrd c%0d got %b exp %b", i, r_mem_nrd, en[i-1]); end
      checks++; if (r_m0_ready !== er0[i-1] || r_m1_ready !== er1[i-1]) begin errors++; $display("FAIL rr_ready c%0d got %b%b exp %b%b", i, r_m0_ready, r_m1_ready, er0[i-1], er1[i-1]); end
      if (i == 4) begin
        checks++; if (r_mem_address !== 32'h0000_0200) begin errors++; $display("FAIL rr_addr_m1 got %h exp 00000200", r_mem_address); end
      end
      if (i == 2) begin
        checks++; if (r_m0_rdata !== 32'hA000_0001) begin errors++; $display("FAIL rr_rdata_c2 got %h exp a0000001", r_m0_rdata); end
      end
      mem_rdata = 32'hA000_0000 + 32'(i);
    end
    checks++; if (r_m0_rdata !== 32'hA000_0007) begin errors++; $display("FAIL rr_m0_rdata got %h exp a0000007", r_m0_rdata); end
    checks++; if (r_m1_rdata !== 32'hA000_000A) begin errors++; $display("FAIL rr_m1_rdata got %h exp a000000a", r_m1_rdata); end
    m0_nrd = 1'b1; m1_nrd = 1'b1;
    step();
  endtask

  task automatic test_write();
    m1_nrd = 1'b1; m1_nwr = 4'b1110; m1_address = 32'h4000_0004; m1_wdata = 32'h0000_00A5;
    mem_rdata = 32'h5555_5555;
    #1;
    checks++; if (r_m0_ready !== 1'b1 || r_m1_ready !== 1'b0) begin errors++; $display("FAIL wr_c0_ready got %b%b exp 10", r_m0_ready, r_m1_ready); end
    step();
    checks++; if (r_mem_nwr !== 4'b1110 || r_mem_nrd !== 1'b1) begin errors++; $display("FAIL wr_c1_strobe got nwr %b nrd %b exp 1110 1", r_mem_nwr, r_mem_nrd); end
    checks++; if (r_mem_address !== 32'h4000_0004 || r_mem_wdata !== 32'h0000_00A5) begin errors++; $display("FAIL wr_c1_addr_data got %h %h exp 40000004 000000a5", r_mem_address, r_mem_wdata); end
    checks++; if (r_grant !== 2'b10 || r_m0_ready !== 1'b1) begin errors++; $display("FAIL wr_c1_grant got %b rdy0 %b exp 10 1", r_grant, r_m0_ready); end
    m1_address = 32'h1234_5678; m1_wdata = 32'hFFFF_FFFF; m1_nwr = 4'b0000;
    step();
    checks++; if (r_mem_nwr !== 4'hF || r_m1_ready !== 1'b1 || r_m0_ready !== 1'b1) begin errors++; $display("FAIL wr_c2 got nwr %h rdy %b%b exp f 11", r_mem_nwr, r_m0_ready, r_m1_ready); end
    checks++; if (r_mem_address !== 32'h4000_0004 || r_mem_wdata !== 32'h0000_00A5) begin errors++; $display("FAIL wr_c2_stable got %h %h exp 40000004 000000a5", r_mem_address, r_mem_wdata); end
    checks++; if (r_m1_rdata !== 32'hA000_000A || r_m0_rdata !== 32'hA000_0007) begin errors++; $display("FAIL wr_rdata got %h %h exp a0000007 a000000a", r_m0_rdata, r_m1_rdata); end
    m1_nwr = 4'hF;
    step();
    checks++; if (r_grant !== 2'b00) begin errors++; $display("FAIL wr_c3_grant got %b exp 00", r_grant); end
  endtask

  task automatic test_mem_wait();
    logic en [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic er [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    m0_nrd = 1'b0; m0_address = 32'h4000_0030; mem_ready = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++; if (r_mem_nrd !== en[c-1]) begin errors++; $display("FAIL mw_mem_nrd c%0d got %b exp %b", c, r_mem_nrd, en[c-1]); end
      checks++; if (r_m0_ready !== er[c-1]) begin errors++; $display("FAIL mw_ready c%0d got %b exp %b", c, r_m0_ready, er[c-1]); end
      if (c < 5) begin
        checks++; if (r_m0_rdata !== 32'hA000_0007) begin errors++; $display("FAIL mw_rdata_hold c%0d got %h exp a0000007", c, r_m0_rdata); end
      end
      if (c == 4) begin
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
      end
    end
    checks++; if (r_m0_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL mw_rdata got %h exp cafef00d", r_m0_rdata); end
    m0_nrd = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    m0_nrd = 1'b0; m0_address = 32'h4000_0020; mem_ready = 1'b1; mem_rdata = 32'h1357_2468;
    step();
    checks++; if (r_mem_nrd !== 1'b0) begin errors++; $display("FAIL rm_c1_nrd got %b exp 0", r_mem_nrd); end
    reset = 1'b1;
    step();
    checks++; if (r_mem_nrd !== 1'b1 || r_mem_nwr !== 4'hF || r_grant !== 2'b00) begin errors++; $display("FAIL rm_c2 got nrd %b nwr %h grant %b exp 1 f 00", r_mem_nrd, r_mem_nwr, r_grant); end
    checks++; if (r_m0_rdata !== 32'h0 || r_m1_rdata !== 32'h0) begin errors++; $display("FAIL rm_rdata got %h %h exp 0 0", r_m0_rdata, r_m1_rdata); end
    checks++; if (r_m0_ready !== 1'b0) begin errors++; $display("FAIL rm_no_ready got %b exp 0", r_m0_ready); end
    reset = 1'b0;
    step();
    checks++; if (r_mem_nrd !== 1'b0 || r_grant !== 2'b01 || r_m0_ready !== 1'b0) begin errors++; $display("FAIL rm_c3 got nrd %b grant %b rdy %b exp 0 01 0", r_mem_nrd, r_grant, r_m0_ready); end
    step();
    checks++; if (r_m0_ready !== 1'b1 || r_m0_rdata !== 32'h1357_2468) begin errors++; $display("FAIL rm_c4 got rdy %b rdata %h exp 1 13572468", r_m0_ready, r_m0_rdata); end
    m0_nrd = 1'b1;
    step();
  endtask

  task automatic test_fixed_prio();
    logic [1:0] eg [12] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    logic       er [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    m0_nrd = 1'b0; m0_address = 32'h0000_0300;
    m1_nrd = 1'b0; m1_address = 32'h0000_0400;
    mem_rdata = 32'h7777_7777;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++; if (p_grant !== eg[i-1]) begin errors++; $display("FAIL fp_grant c%0d got %b exp %b", i, p_grant, eg[i-1]); end
      checks++; if (p_m1_ready !== 1'b0 || p_m0_ready !== er[i-1]) begin errors++; $display("FAIL fp_ready c%0d got %b%b exp %b0", i, p_m0_ready, p_m1_ready, er[i-1]); end
    end
    m0_nrd = 1'b1;
    step();
    checks++; if (p_grant !== 2'b10 || p_mem_address !== 32'h0000_0400) begin errors++; $display("FAIL fp_m1_grant got %b %h exp 10 00000400", p_grant, p_mem_address); end
    step();
    checks++; if (p_m1_ready !== 1'b1 || p_m1_rdata !== 32'h7777_7777) begin errors++; $display("FAIL fp_m1_done got %b %h exp 1 77777777", p_m1_ready, p_m1_rdata); end
    m1_nrd = 1'b1;
    step();
  endtask

  task automatic test_wait_states();
    logic en [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic er [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    // read and write strobes together are forwarded unchanged
    m0_nrd = 1'b0; m0_nwr = 4'b0011; m0_address = 32'h4000_0040; mem_rdata = 32'h2468_ACE0;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++; if (w_mem_nrd !== en[c-1] || w_m0_ready !== er[c-1]) begin errors++; $display("FAIL ws_c%0d got nrd %b rdy %b exp %b %b", c, w_mem_nrd, w_m0_ready, en[c-1], er[c-1]); end
      if (c == 1) begin
        checks++; if (w_mem_nwr !== 4'b0011) begin errors++; $display("FAIL ws_nwr_fwd got %b exp 0011", w_mem_nwr); end
      end
    end
    checks++; if (w_m0_rdata !== 32'h2468_ACE0) begin errors++; $display("FAIL ws_rdata got %h exp 2468ace0", w_m0_rdata); end
    m0_nrd = 1'b1; m0_nwr = 4'hF;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_reset();
    test_round_robin();
    test_write();
    test_mem_wait();
    test_reset_mid();
    test_fixed_prio();
    test_wait_states();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
